// File: rtl/int_ctrl_pkg.sv
// Shared types and width helpers for the interrupt controller.
package int_ctrl_pkg;

    // Controller states: maskable request/service plus the NMI request/service pair.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_SERV,
        ST_NMI_REQ,
        ST_NMI_SERV
    } state_e;

    // Vector width: enough to encode channels 0..n_irq-1 plus the NMI vector.
    function automatic int vec_w(input int n_irq);
        return $clog2(n_irq + 1);
    endfunction

    // The NMI uses the first vector past the maskable channels.
    function automatic int nmi_vec(input int n_irq);
        return n_irq;
    endfunction

endpackage

// File: rtl/int_prio_enc.sv
// Combinational priority encoder: the lowest set bit wins.
module int_prio_enc #(
    parameter int N     = 8,
    parameter int IDX_W = 4
) (
    input  logic [N-1:0]     req,
    output logic             valid,
    output logic [IDX_W-1:0] index
);

    // Scan from the top down so the lowest requesting index is the last one written.
    always_comb begin
        // NOTE: defaults first so every path assigns every output; otherwise a latch is inferred.
        valid = 1'b0;
        index = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                index = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/int_controller.sv
// Vectored interrupt controller: N_IRQ maskable channels (edge or level), one NMI,
// a single level of NMI nesting over a maskable handler.
module int_controller
    import int_ctrl_pkg::*;
#(
    parameter int               N_IRQ     = 8,
    parameter logic [N_IRQ-1:0] EDGE_MASK = '1,
    parameter logic [N_IRQ-1:0] MASK_RST  = '0,
    localparam int              VEC_W     = vec_w(N_IRQ)
) (
    input  logic             clk,
    input  logic             initiate,
    input  logic [N_IRQ-1:0] irq,
    input  logic             nmi,
    input  logic             intd,
    input  logic             mask_we,
    input  logic [N_IRQ-1:0] mask_wdata,
    input  logic             ack,
    input  logic             eret,
    output logic             int_req,
    output logic [VEC_W-1:0] int_vec,
    output logic             int_nmi,
    output logic [N_IRQ-1:0] pending,
    output logic [N_IRQ-1:0] mask,
    output logic             in_service
);

    localparam logic [VEC_W-1:0] NMI_VEC = VEC_W'(nmi_vec(N_IRQ));
    localparam logic [N_IRQ-1:0] ONE     = N_IRQ'(1);

    state_e             state;
    logic [N_IRQ-1:0]   irq_q;
    logic               nmi_q;
    logic               nmi_pend;
    logic               nest;
    logic [VEC_W-1:0]   serv_vec;

    logic [N_IRQ-1:0]   eligible;
    logic [N_IRQ-1:0]   chosen_sel;
    logic [N_IRQ-1:0]   clr;
    logic               chosen_ok;
    logic               enc_valid;
    logic [VEC_W-1:0]   enc_idx;

    // Channels that may raise a request now; the chosen one is tracked while in REQ.
    always_comb begin
        eligible   = intd ? '0 : (pending & ~mask);
        chosen_sel = ONE << int_vec;
        chosen_ok  = |(eligible & chosen_sel);
        clr        = (state == ST_REQ && ack) ? chosen_sel : '0;
    end

    int_prio_enc #(
        .N     (N_IRQ),
        .IDX_W (VEC_W)
    ) u_enc (
        .req   (eligible),
        .valid (enc_valid),
        .index (enc_idx)
    );

    // Input edge history, pending bits, NMI latch and the mask register.
    always_ff @(posedge clk or negedge initiate) begin
        if (!initiate) begin
            irq_q    <= '0;
            nmi_q    <= 1'b0;
            pending  <= '0;
            nmi_pend <= 1'b0;
            mask     <= MASK_RST;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values, independent of statement order.
            irq_q    <= irq;
            nmi_q    <= nmi;
            // Edge channels: new edge beats a same-cycle ack. Level channels follow the registered line.
            pending  <= (EDGE_MASK & ((irq & ~irq_q) | (pending & ~clr))) | (~EDGE_MASK & irq);
            nmi_pend <= (nmi & ~nmi_q) | (nmi_pend & ~(state == ST_NMI_REQ && ack));
            if (mask_we) mask <= mask_wdata;
        end
    end

    // Request/service sequencing with registered CPU-facing outputs.
    always_ff @(posedge clk or negedge initiate) begin
        if (!initiate) begin
            state      <= ST_IDLE;
            int_req    <= 1'b0;
            int_vec    <= '0;
            int_nmi    <= 1'b0;
            in_service <= 1'b0;
            nest       <= 1'b0;
            serv_vec   <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (nmi_pend) begin
                        state   <= ST_NMI_REQ;
                        int_req <= 1'b1;
                        int_vec <= NMI_VEC;
                        int_nmi <= 1'b1;
                    end else if (enc_valid) begin
                        state   <= ST_REQ;
                        int_req <= 1'b1;
                        int_vec <= enc_idx;
                        int_nmi <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (ack) begin
                        state      <= ST_SERV;
                        int_req    <= 1'b0;
                        in_service <= 1'b1;
                        serv_vec   <= int_vec;
                    end else if (nmi_pend) begin
                        // Maskable request stays pending and is re-arbitrated after the NMI.
                        state   <= ST_NMI_REQ;
                        int_vec <= NMI_VEC;
                        int_nmi <= 1'b1;
                    end else if (!chosen_ok) begin
                        state   <= ST_IDLE;
                        int_req <= 1'b0;
                    end
                end
                ST_SERV: begin
                    if (eret) begin
                        state      <= ST_IDLE;
                        in_service <= 1'b0;
                    end else if (nmi_pend) begin
                        state      <= ST_NMI_REQ;
                        nest       <= 1'b1;
                        int_req    <= 1'b1;
                        int_vec    <= NMI_VEC;
                        int_nmi    <= 1'b1;
                        in_service <= 1'b0;
                    end
                end
                ST_NMI_REQ: begin
                    if (ack) begin
                        state      <= ST_NMI_SERV;
                        int_req    <= 1'b0;
                        in_service <= 1'b1;
                    end
                end
                ST_NMI_SERV: begin
                    if (eret) begin
                        int_nmi <= 1'b0;
                        if (nest) begin
                            // Resume the interrupted maskable handler.
                            state   <= ST_SERV;
                            nest    <= 1'b0;
                            int_vec <= serv_vec;
                        end else begin
                            state      <= ST_IDLE;
                            in_service <= 1'b0;
                        end
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    int_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_int_controller.sv
// Directed bench for int_controller: defaults instance plus a level-channel instance.
module tb_int_controller;

    localparam int N = 8;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         initiate;
    logic [N-1:0] irq, irq2, mask_wdata;
    logic         nmi, intd, mask_we, ack, eret;
    logic         int_req, int_nmi, in_service;
    logic [W-1:0] int_vec;
    logic [N-1:0] pending, mask;

    logic         l_req, l_nmi, l_serv;
    logic [W-1:0] l_vec;
    logic [N-1:0] l_pend, l_mask;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    int_controller dut (
        .clk(clk), .initiate(initiate), .irq(irq), .nmi(nmi), .intd(intd),
        .mask_we(mask_we), .mask_wdata(mask_wdata), .ack(ack), .eret(eret),
        .int_req(int_req), .int_vec(int_vec), .int_nmi(int_nmi),
        .pending(pending), .mask(mask), .in_service(in_service)
    );

    int_controller #(.N_IRQ(8), .EDGE_MASK(8'hFE)) dut_lvl (
        .clk(clk), .initiate(initiate), .irq(irq2), .nmi(1'b0), .intd(1'b0),
        .mask_we(1'b0), .mask_wdata(8'h00), .ack(1'b0), .eret(1'b0),
        .int_req(l_req), .int_vec(l_vec), .int_nmi(l_nmi),
        .pending(l_pend), .mask(l_mask), .in_service(l_serv)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    initial begin
        initiate = 1'b0; irq = '0; irq2 = '0; nmi = 0; intd = 0;
        mask_we = 0; mask_wdata = '0; ack = 0; eret = 0;
        tick(); tick();
        check("rst_req", {31'd0, int_req}, 0);
        check("rst_vec", {28'd0, int_vec}, 0);
        check("rst_pend", {24'd0, pending}, 0);
        check("rst_serv", {31'd0, in_service}, 0);

        // Single edge on channel 3: two-cycle latency, ack clears, eret returns.
        initiate = 1'b1; irq = 8'h08;
        tick(); irq = '0;
        check("lat_early", {31'd0, int_req}, 0);
        tick();
        check("lat_req", {31'd0, int_req}, 1);
        check("lat_vec", {28'd0, int_vec}, 3);
        ack = 1; tick(); ack = 0;
        check("ack_pend", {24'd0, pending}, 0);
        check("ack_serv", {31'd0, in_service}, 1);
        check("ack_req", {31'd0, int_req}, 0);
        eret = 1; tick(); eret = 0;
        check("eret_serv", {31'd0, in_service}, 0);

        // Two channels at once: lower index first, the other afterwards.
        irq = 8'h24; tick(); irq = '0; tick();
        check("prio_vec", {28'd0, int_vec}, 2);
        check("prio_pend", {24'd0, pending}, 32'h24);
        ack = 1; tick(); ack = 0;
        check("prio_left", {24'd0, pending}, 32'h20);
        eret = 1; tick(); eret = 0; tick();
        check("second_req", {31'd0, int_req}, 1);
        check("second_vec", {28'd0, int_vec}, 5);
        ack = 1; tick(); ack = 0; eret = 1; tick(); eret = 0;

        // Masking, then unmasking, then the global disable.
        mask_we = 1; mask_wdata = 8'h04; tick(); mask_we = 0;
        check("mask_rd", {24'd0, mask}, 32'h04);
        irq = 8'h04; tick(); irq = '0; tick(); tick();
        check("masked_req", {31'd0, int_req}, 0);
        check("masked_pend", {24'd0, pending}, 32'h04);
        mask_we = 1; mask_wdata = 8'h00; tick(); mask_we = 0; tick();
        check("unmask_req", {31'd0, int_req}, 1);
        check("unmask_vec", {28'd0, int_vec}, 2);
        ack = 1; tick(); ack = 0; eret = 1; tick(); eret = 0;
        intd = 1; irq = 8'h04; tick(); irq = '0; tick(); tick();
        check("intd_req", {31'd0, int_req}, 0);
        intd = 0; tick();
        check("intd_off_req", {31'd0, int_req}, 1);
        check("intd_off_vec", {28'd0, int_vec}, 2);
        ack = 1; tick(); ack = 0; eret = 1; tick(); eret = 0;

        // NMI nested over the handler for vector 1.
        irq = 8'h02; tick(); irq = '0; tick();
        check("v1_vec", {28'd0, int_vec}, 1);
        ack = 1; tick(); ack = 0;
        nmi = 1; tick(); nmi = 0; tick();
        check("nmi_req", {31'd0, int_req}, 1);
        check("nmi_vec", {28'd0, int_vec}, 8);
        check("nmi_flag", {31'd0, int_nmi}, 1);
        ack = 1; tick(); ack = 0;
        check("nmi_serv", {31'd0, in_service}, 1);
        check("nmi_serv_req", {31'd0, int_req}, 0);
        eret = 1; tick(); eret = 0;
        check("nest_serv", {31'd0, in_service}, 1);
        check("nest_nmi", {31'd0, int_nmi}, 0);
        check("nest_vec", {28'd0, int_vec}, 1);
        eret = 1; tick(); eret = 0;
        check("nest_idle", {31'd0, in_service}, 0);

        // Level channel withdrawn before ack drops the request.
        irq2 = 8'h01; tick(); tick();
        check("lvl_req", {31'd0, l_req}, 1);
        check("lvl_vec", {28'd0, l_vec}, 0);
        irq2 = '0; tick(); tick();
        check("lvl_drop_req", {31'd0, l_req}, 0);
        check("lvl_drop_pend", {24'd0, l_pend}, 0);

        // Asynchronous reset from NMI_SERV with a masked pending bit and a held line.
        mask_we = 1; mask_wdata = 8'hF0; tick(); mask_we = 0;
        irq = 8'h10; tick(); irq = '0;
        nmi = 1; tick(); nmi = 0; tick();
        ack = 1; tick(); ack = 0;
        check("pre_rst_serv", {31'd0, in_service}, 1);
        check("pre_rst_pend", {24'd0, pending}, 32'h10);
        irq = 8'h01;
        #2 initiate = 1'b0;
        #1;
        check("arst_serv", {31'd0, in_service}, 0);
        check("arst_nmi", {31'd0, int_nmi}, 0);
        check("arst_req", {31'd0, int_req}, 0);
        check("arst_vec", {28'd0, int_vec}, 0);
        check("arst_pend", {24'd0, pending}, 0);
        check("arst_mask", {24'd0, mask}, 0);
        #1 initiate = 1'b1;
        tick(); tick();
        check("rel_edge_req", {31'd0, int_req}, 1);
        check("rel_edge_vec", {28'd0, int_vec}, 0);
        irq = '0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/int_controller.md
INT_CONTROLLER -- requirements
Module: int_controller

Interface
REQ-001 Parameter N_IRQ, 8, number of maskable interrupt channels (1..32).
REQ-002 Parameter EDGE_MASK, all-ones N_IRQ bits, per-channel mode: 1 = rising-edge latched, 0 = level.
REQ-003 Parameter MASK_RST, 0, reset value of the mask register (1 = channel masked).
REQ-004 Derived constant VEC_W = clog2(N_IRQ+1); vector N_IRQ is reserved for NMI.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 initiate  in  1  reset, asynchronous, active-low.
REQ-007 irq  in  N_IRQ  maskable interrupt lines, synchronous to clk.
REQ-008 nmi  in  1  non-maskable interrupt, rising-edge triggered.
REQ-009 intd  in  1  global disable of maskable interrupts (level).
REQ-010 mask_we  in  1  mask register write strobe.
REQ-011 mask_wdata  in  N_IRQ  mask write data.
REQ-012 ack  in  1  CPU accepts the presented vector.
REQ-013 eret  in  1  CPU returns from the current handler.
REQ-014 int_req  out  1  interrupt request to CPU.
REQ-015 int_vec  out  VEC_W  vector of the requested interrupt.
REQ-016 int_nmi  out  1  current request/service is the NMI.
REQ-017 pending  out  N_IRQ  pending bits.
REQ-018 mask  out  N_IRQ  mask register contents.
REQ-019 in_service  out  1  high in SERV or NMI_SERV.

Function
REQ-020 Edge channel: pending bit set on irq & ~irq_q; cleared only by ack of that channel; set wins over same-cycle clear.
REQ-021 Level channel: pending bit equals registered irq; ack does not clear it.
REQ-022 nmi_pend set on nmi rising edge, cleared by ack in NMI_REQ; set wins; unaffected by mask and intd.
REQ-023 eligible = pending & ~mask, forced to zero while intd = 1; lowest index has highest priority.
REQ-024 mask_we loads mask_wdata; new mask affects eligibility from the following cycle.
REQ-025 States: IDLE, REQ, SERV, NMI_REQ, NMI_SERV; int_req = 1 exactly in REQ and NMI_REQ.
REQ-026 IDLE: nmi_pend -> NMI_REQ; else eligible != 0 -> REQ with int_vec latched to the winning index; NMI has precedence.
REQ-027 REQ: int_vec frozen; ack -> SERV; nmi_pend (no ack) -> NMI_REQ, maskable stays pending; chosen channel no longer eligible (no ack) -> IDLE.
REQ-028 SERV: eret -> IDLE; nmi_pend -> NMI_REQ with nest flag set; other maskable requests wait (no maskable nesting).
REQ-029 NMI_REQ: int_vec = N_IRQ, int_nmi = 1; ack -> NMI_SERV.
REQ-030 NMI_SERV: eret -> SERV if nest flag set (flag cleared), else IDLE; new NMI edges latch and are taken after return.
REQ-031 ack outside REQ/NMI_REQ and eret outside SERV/NMI_SERV are ignored.
REQ-032 Latency: edge on irq at cycle n -> int_req high from cycle n+2 (pending in n+1, state in n+2).

Reset
REQ-033 While initiate = 0: state IDLE, pending 0, nmi_pend 0, nest flag 0, irq_q 0, nmi_q 0, mask = MASK_RST, int_req 0, int_vec 0, int_nmi 0, in_service 0.
REQ-034 Reset mid-request or mid-service aborts immediately; lines high at release register as edges.

Structure
REQ-035 Package int_ctrl_pkg holds the state enum and the NMI vector / VEC_W helper.
REQ-036 Sub-module int_prio_enc: combinational lowest-index priority encoder (valid, index).

Verification (N_IRQ=8, defaults)
REQ-037 Reset release, irq=0x08 pulse -> int_req in 2 cycles, int_vec=3; ack -> pending[3]=0, in_service=1; eret -> IDLE.
REQ-038 irq=0x24 same cycle -> int_vec=2; after ack+eret -> int_vec=5.
REQ-039 mask=0x04 then irq=0x04 -> no int_req; mask=0x00 -> int_req, int_vec=2; intd=1 blocks identically.
REQ-040 In SERV of vector 1, nmi edge -> int_vec=8, int_nmi=1; ack, eret -> back to SERV (in_service=1, int_nmi=0).
REQ-041 Level channel (EDGE_MASK=0xFE) irq[0] held then dropped in REQ before ack -> IDLE, int_req=0.
REQ-042 initiate=0 in NMI_SERV -> all outputs per REQ-033 asynchronously, without waiting for a clk edge.
